// File: rtl/uart_frame_tx.sv
// Packetiser in front of a byte-level UART transmitter.
// Emits HEAD0 HEAD1 LEN {lo,hi}*LEN CHK and aborts the frame if a byte is never acknowledged.
module uart_frame_tx #(
    parameter int unsigned MAX_LEN     = 64,
    parameter logic [7:0]  HEAD0       = 8'h55,
    parameter logic [7:0]  HEAD1       = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start_i,
    input  logic [7:0]  frame_len_i,
    input  logic        sample_valid_i,
    input  logic [15:0] sample_data_i,
    output logic        sample_ready_o,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_done_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o
);

    localparam int unsigned WdW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]  MaxLen8 = 8'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StSend, StWaitDone, StFetch, StEnd} state_e;
    typedef enum logic [2:0] {SelHead0, SelHead1, SelLen, SelLo, SelHi, SelChk} sel_e;

    state_e           state_q;
    sel_e             sel_q;
    logic [7:0]       len_q;
    logic [7:0]       cnt_q;
    logic [7:0]       chk_q;
    logic [15:0]      word_q;
    logic [WdW-1:0]   wd_q;
    logic [7:0]       cur_byte;

    always_comb begin
        cur_byte = HEAD0;
        case (sel_q)
            SelHead0: cur_byte = HEAD0;
            SelHead1: cur_byte = HEAD1;
            SelLen:   cur_byte = len_q;
            SelLo:    cur_byte = word_q[7:0];
            SelHi:    cur_byte = word_q[15:8];
            SelChk:   cur_byte = chk_q;
            default:  cur_byte = HEAD0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            sel_q          <= SelHead0;
            len_q          <= 8'h00;
            cnt_q          <= 8'h00;
            chk_q          <= 8'h00;
            word_q         <= 16'h0000;
            wd_q           <= '0;
            sample_ready_o <= 1'b0;
            tx_start_o     <= 1'b0;
            tx_data_o      <= 8'h00;
            busy_o         <= 1'b0;
            frame_done_o   <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            tx_start_o   <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (frame_start_i) begin
                        if (frame_len_i == 8'h00 || frame_len_i > MaxLen8) begin
                            err_o <= 1'b1;
                        end else begin
                            len_q   <= frame_len_i;
                            chk_q   <= 8'h00;
                            cnt_q   <= 8'h00;
                            sel_q   <= SelHead0;
                            busy_o  <= 1'b1;
                            state_q <= StSend;
                        end
                    end
                end
                StSend: begin
                    tx_start_o <= 1'b1;
                    tx_data_o  <= cur_byte;
                    wd_q       <= '0;
                    // Headers are excluded from the checksum.
                    if (sel_q inside {SelLen, SelLo, SelHi}) begin
                        chk_q <= chk_q + cur_byte;
                    end
                    state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (tx_done_i) begin
                        case (sel_q)
                            SelHead0: begin
                                sel_q   <= SelHead1;
                                state_q <= StSend;
                            end
                            SelHead1: begin
                                sel_q   <= SelLen;
                                state_q <= StSend;
                            end
                            SelLen: begin
                                sample_ready_o <= 1'b1;
                                state_q        <= StFetch;
                            end
                            SelLo: begin
                                sel_q   <= SelHi;
                                state_q <= StSend;
                            end
                            SelHi: begin
                                cnt_q <= cnt_q + 8'd1;
                                if (cnt_q + 8'd1 == len_q) begin
                                    sel_q   <= SelChk;
                                    state_q <= StSend;
                                end else begin
                                    sample_ready_o <= 1'b1;
                                    state_q        <= StFetch;
                                end
                            end
                            SelChk: begin
                                frame_done_o <= 1'b1;
                                busy_o       <= 1'b0;
                                state_q      <= StEnd;
                            end
                            default: begin
                                busy_o  <= 1'b0;
                                state_q <= StIdle;
                            end
                        endcase
                    end else if (wd_q + WdW'(1) == WdW'(TIMEOUT_CYC)) begin
                        err_o   <= 1'b1;
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        wd_q <= wd_q + WdW'(1);
                    end
                end
                StFetch: begin
                    if (sample_valid_i && sample_ready_o) begin
                        word_q         <= sample_data_i;
                        sample_ready_o <= 1'b0;
                        sel_q          <= SelLo;
                        state_q        <= StSend;
                    end
                end
                // One dead cycle so a start coincident with frame_done_o is dropped.
                StEnd: state_q <= StIdle;
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
